// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared defaults, derived index widths and the read-response
//                record for the set-associative cache datapaths.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

  localparam int DEF_WAYS           = 4;
  localparam int DEF_WORD_W         = 16;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_TAG_W          = 8;
  localparam int DEF_CNT_W          = 16;

  localparam int WAY_IDX_W  = $clog2(DEF_WAYS);
  localparam int WORD_IDX_W = $clog2(DEF_WORDS_PER_LINE);

  // One read response at the default geometry
  typedef struct packed {
    logic                  hit;
    logic                  multi_hit;
    logic [WAY_IDX_W-1:0]  way;
    logic [DEF_WORD_W-1:0] data;
  } rsp_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/hit_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : hit_encoder
//  Description : Any-hot way match vector to lowest-index binary way number,
//                with any-hit and multi-hit flags. Purely combinational so it
//                can be shared by the read-hit and write-hit paths.
//  Revision    : 1.0  initial release
// ============================================================================
module hit_encoder #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-1:0]         i_match,
  output logic [$clog2(WAYS)-1:0] o_idx,
  output logic                    o_any,
  output logic                    o_multi
);

  localparam int              C_IDX_W = $clog2(WAYS);
  localparam logic [WAYS-1:0] C_ONE   = WAYS'(1);

  // Scan from the top so the lowest matching way is the last one written
  always_comb begin
    o_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (i_match[i]) begin
        o_idx = C_IDX_W'(i);
      end
    end
  end

  assign o_any   = |i_match;
  // Clearing the lowest set bit leaves something only if two or more were set
  assign o_multi = |(i_match & (i_match - C_ONE));

endmodule : hit_encoder
`default_nettype wire

// File: rtl/cache_read_hit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cache_read_hit_pipe
//  Description : Two-stage read-hit datapath: tag compare and way select in
//                stage 1, word select in stage 2, valid/ready on both sides,
//                plus saturating hit/miss statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_read_hit_pipe
  import cache_pkg::*;
#(
  parameter int WAYS           = DEF_WAYS,
  parameter int WORD_W         = DEF_WORD_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int TAG_W          = DEF_TAG_W,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [TAG_W-1:0]                     req_tag,
  input  logic [$clog2(WORDS_PER_LINE)-1:0]    req_word,
  input  logic [WAYS*TAG_W-1:0]                way_tag,
  input  logic [WAYS-1:0]                      way_vld,
  input  logic [WAYS*WORDS_PER_LINE*WORD_W-1:0] way_line,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic                                 rsp_hit,
  output logic [$clog2(WAYS)-1:0]              rsp_way,
  output logic [WORD_W-1:0]                    rsp_data,
  output logic                                 rsp_multi_hit,
  input  logic                                 clear_stats,
  output logic [CNT_W-1:0]                     hit_cnt,
  output logic [CNT_W-1:0]                     miss_cnt
);

  localparam int               C_WAY_W   = $clog2(WAYS);
  localparam int               C_WRD_W   = $clog2(WORDS_PER_LINE);
  localparam int               C_LINE_W  = WORDS_PER_LINE * WORD_W;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // Flow control
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_rsp_fire;

  // Stage 1 combinational lookup
  logic [WAYS-1:0]     w_match;
  logic [C_WAY_W-1:0]  w_way;
  logic                w_hit;
  logic                w_multi;
  logic [C_LINE_W-1:0] w_lines [WAYS];

  // Stage 1 registers
  logic                r_s1_valid;
  logic                r_s1_hit;
  logic                r_s1_multi;
  logic [C_WAY_W-1:0]  r_s1_way;
  logic [C_WRD_W-1:0]  r_s1_word;
  logic [C_LINE_W-1:0] r_s1_line;

  // Stage 2 combinational word select
  logic [WORD_W-1:0] w_words [WORDS_PER_LINE];
  logic [WORD_W-1:0] w_sel_word;

  // Stage 2 / response registers
  logic               r_rsp_valid;
  logic               r_rsp_hit;
  logic               r_rsp_multi;
  logic [C_WAY_W-1:0] r_rsp_way;
  logic [WORD_W-1:0]  r_rsp_data;

  // Statistics
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  // A stage may load when it is empty or its contents move on this cycle
  assign w_s2_adv   = !r_rsp_valid || rsp_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign req_ready  = w_s1_adv;
  assign w_rsp_fire = r_rsp_valid && rsp_ready;

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_ways
      assign w_match[g] = way_vld[g] && (way_tag[g*TAG_W +: TAG_W] == req_tag);
      assign w_lines[g] = way_line[g*C_LINE_W +: C_LINE_W];
    end
  endgenerate

  hit_encoder #(
    .WAYS (WAYS)
  ) u_hit_encoder (
    .i_match (w_match),
    .o_idx   (w_way),
    .o_any   (w_hit),
    .o_multi (w_multi)
  );

  // Stage 1: capture compare result and the lowest matching way's line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_multi <= 1'b0;
      r_s1_way   <= '0;
      r_s1_word  <= '0;
      r_s1_line  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= req_valid;
      if (req_valid) begin
        r_s1_hit   <= w_hit;
        r_s1_multi <= w_multi;
        r_s1_way   <= w_way;
        r_s1_word  <= req_word;
        r_s1_line  <= w_lines[w_way];
      end
    end
  end

  generate
    for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_words
      assign w_words[g] = r_s1_line[g*WORD_W +: WORD_W];
    end
  endgenerate

  assign w_sel_word = w_words[r_s1_word];

  // Stage 2: pick the word and present the response; misses report way 0, data 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_multi <= 1'b0;
      r_rsp_way   <= '0;
      r_rsp_data  <= '0;
    end else if (w_s2_adv) begin
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_hit   <= r_s1_hit;
        r_rsp_multi <= r_s1_multi;
        r_rsp_way   <= r_s1_hit ? r_s1_way : '0;
        r_rsp_data  <= r_s1_hit ? w_sel_word : '0;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (clear_stats) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_rsp_fire) begin
      if (r_rsp_hit) begin
        if (r_hit_cnt != C_CNT_MAX) begin
          r_hit_cnt <= r_hit_cnt + C_CNT_ONE;
        end
      end else begin
        if (r_miss_cnt != C_CNT_MAX) begin
          r_miss_cnt <= r_miss_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_hit       = r_rsp_hit;
  assign rsp_way       = r_rsp_way;
  assign rsp_data      = r_rsp_data;
  assign rsp_multi_hit = r_rsp_multi;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

endmodule : cache_read_hit_pipe
`default_nettype wire

// File: doc/cache_read_hit_pipe.md
Name: cache_read_hit_pipe

Overview:
Parametrised, pipelined read-hit datapath for the N-way set-associative cache.
- Takes one set's per-way tags, valid bits and data lines, plus a request tag and word offset.
- Performs tag compare, hit encoding, way select and word select over two registered stages, with valid/ready handshakes on both sides.
- Sits between the tag/data array read ports and the CPU load-response path; also keeps saturating hit/miss statistics.

Parameters:
WAYS, 4, associativity (power of two, >=2)
WORD_W, 16, data word width in bits
WORDS_PER_LINE, 4, words per line (power of two, >=2)
TAG_W, 8, tag width in bits
CNT_W, 16, width of hit/miss statistic counters

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block accepts request this cycle
req_tag  in  TAG_W  lookup tag
req_word  in  $clog2(WORDS_PER_LINE)  word offset within line
way_tag  in  WAYS*TAG_W  per-way stored tags; way i at [i*TAG_W +: TAG_W]
way_vld  in  WAYS  per-way valid bits
way_line  in  WAYS*WORDS_PER_LINE*WORD_W  per-way lines; word 0 in LSBs of each line
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_hit  out  1  1 = hit, 0 = miss
rsp_way  out  $clog2(WAYS)  hitting way index (0 on miss)
rsp_data  out  WORD_W  selected word (0 on miss)
rsp_multi_hit  out  1  more than one valid way matched (error flag)
clear_stats  in  1  synchronous clear of counters
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset (rst_n=0 sampled at clk): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_data=0, rsp_multi_hit=0, hit_cnt=0, miss_cnt=0. req_ready is combinational and therefore reads 1 after reset. Reset mid-operation discards in-flight requests; no response is produced for them.
- Handshake: a transfer occurs when valid&&ready, on both sides. rsp_valid stays high and rsp_* stay stable until rsp_ready. req_* and way_* are sampled only in the accept cycle.
- Stage 1 (accept cycle):
  - match[i] = way_vld[i] && (way_tag[i]==req_tag).
  - Register: one-hot match; lowest-index matching way's line; req_word; hit=|match; multi = popcount(match)>1.
- Stage 2:
  - Word select: line[req_word*WORD_W +: WORD_W].
  - Register into rsp_*. On miss, rsp_data=0 and rsp_way=0.
  - Multi-hit selects the lowest-index matching way.
- Latency: response visible 2 cycles after accept with no backpressure. Throughput is 1 request/cycle.
- Flow control:
  - s2_adv = !s2_valid || rsp_ready.
  - s1_adv = !s1_valid || s2_adv.
  - req_ready = s1_adv.
  - Stages hold their contents when not advancing. No bubbles are inserted when rsp_ready stays high.
  - Back-to-back requests with rsp_ready low fill both stages, after which req_ready=0.
- Counters:
  - On each response handshake, increment hit_cnt if rsp_hit else miss_cnt.
  - Both counters saturate at 2^CNT_W-1.
  - clear_stats has priority over a simultaneous increment (result 0 that cycle).
  - Multi-hit counts as a hit.
- Arithmetic: all index math is unsigned with $clog2 widths. No truncation warnings are permitted.

Decomposition:
- Package cache_pkg:
  - default parameter constants;
  - WAY_IDX_W and WORD_IDX_W localparams derived via $clog2;
  - typedef rsp_t struct {hit, multi_hit, way, data}.
- Sub-module hit_encoder: WAYS-bit one-hot/any-hot to lowest-index binary, plus any-hit and multi-hit outputs. It is combinational and reused by the write-hit path.
- Top: the two pipeline registers, flow control and counters.

Test Plan:
1. Reset then hit: way_vld=4'b1111, way_tag={8'h40,8'h30,8'h20,8'h10}, req_tag=8'h30, req_word=2, way 2 line=64'hDDDD_CCCC_BBBB_AAAA, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_hit=1, rsp_way=2, rsp_data=16'hCCCC; hit_cnt=1 after handshake.
2. Miss: req_tag=8'h55 with no match, or way_vld=0 on the matching way -> rsp_hit=0, rsp_way=0, rsp_data=0, miss_cnt increments.
3. Multi-hit: ways 1 and 3 both valid with tag 8'h22, req_word=0 -> rsp_way=1, rsp_multi_hit=1, data taken from way 1 word 0.
4. Backpressure: 4 back-to-back requests with rsp_ready=0 -> req_ready drops after 2 accepts; rsp_* stay stable. Releasing rsp_ready delivers responses in order, with no loss or duplication.
5. Counter saturation/clear: CNT_W=4, 17 hits -> hit_cnt=15. clear_stats asserted in the same cycle as a hit handshake -> hit_cnt=0.
6. Reset mid-flight: assert rst_n=0 with both stages full -> next cycle rsp_valid=0 and counters 0. No stale response appears after reset.
